ax301_segment_scanner: RTL and testbench

//  Time-multiplexed scan controller for the AX301 6-digit 7-segment display.

---
 rtl/ax301_segment_scanner.sv | 199 +++++++++++++++++++
 tb/tb_ax301_segment_scanner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ax301_segment_scanner.sv
// ax301_segment_scanner
//   Time-multiplexed scan controller for the AX301 6-digit 7-segment display.
//   Holds six hex digits plus decimal points and blank flags in a shadow
//   buffer and decodes them. It cycles the digit selects one at a time, with
//   an all-off gap between digits to suppress ghosting. Host updates land in
//   a pending buffer and are copied to the shadow only at a frame boundary,
//   or while idle.
//
// Optional feature: define SEG_SCAN_BRIGHTNESS_EN to add a brightness[3:0]
//   input that shortens the active part of each digit slot.
//
// Ports
//   CLK         system clock
//   nRST        synchronous active-low reset
//   enable      1 = scan, 0 = display off
//   upd_valid   host offers new display content
//   upd_ready   pending buffer empty; update taken on valid & ready
//   upd_digits  six nibbles, digit i = [4i+3:4i]
//   upd_dp      decimal point per digit, 1 = lit
//   upd_blank   1 = digit dark (select still driven)
//   brightness  (optional) active-slot length, 15 = full slot
//   frame_done  1-cycle pulse after the digit-5 slot and its gap
//   seg_ctrl    {sel[5:0], segment[7:0]}, both active-low
module ax301_segment_scanner #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enable,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [23:0] upd_digits,
  input  logic [5:0]  upd_dp,
  input  logic [5:0]  upd_blank,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic        frame_done,
  output logic [13:0] seg_ctrl
);

  localparam int MAXC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;
  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blank;
  } disp_t;

  state_e        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [2:0]    idx_q, idx_d, idx_nxt;
  disp_t         pend_q, pend_d, shadow_q, shadow_d;
  logic          pend_vld_q, pend_vld_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          ready_q, ready_d;
  logic          fd_q, fd_d;
  logic          boundary, accept, apply;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]    bright_q, bright_d;
  logic          sel_on;
`endif

  // Active-low decode, dp bit (bit 7) off.
  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hC0;  4'h1: decode = 8'hF9;
      4'h2: decode = 8'hA4;  4'h3: decode = 8'hB0;
      4'h4: decode = 8'h99;  4'h5: decode = 8'h92;
      4'h6: decode = 8'h82;  4'h7: decode = 8'hF8;
      4'h8: decode = 8'h80;  4'h9: decode = 8'h90;
      4'hA: decode = 8'h88;  4'hB: decode = 8'h83;
      4'hC: decode = 8'hC6;  4'hD: decode = 8'hA1;
      4'hE: decode = 8'h86;  default: decode = 8'h8E;
    endcase
  endfunction

  assign idx_nxt = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  // Next-state: scan sequencing. boundary marks the edge leaving digit 5.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      ctr_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          ctr_d   = '0;
          idx_d   = '0;
        end
        SHOW: begin
          if (ctr_q == SLOT_LAST) begin
            ctr_d = '0;
            if (BLANK_CYCLES == 0) begin
              idx_d    = idx_nxt;
              boundary = (idx_q == 3'd5);
            end else begin
              state_d = BLANK;
            end
          end else begin
            ctr_d = ctr_q + CW'(1);
          end
        end
        BLANK: begin
          if (ctr_q == BLANK_LAST) begin
            ctr_d    = '0;
            state_d  = SHOW;
            idx_d    = idx_nxt;
            boundary = (idx_q == 3'd5);
          end else begin
            ctr_d = ctr_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Double buffering: accept needs an empty pending slot, apply needs a full
  // one, so the two never coincide.
  always_comb begin
    accept     = upd_valid & ready_q;
    apply      = pend_vld_q & (boundary | (state_q == IDLE));
    shadow_d   = apply ? pend_q : shadow_q;
    pend_d     = accept ? disp_t'{upd_digits, upd_dp, upd_blank} : pend_q;
    pend_vld_d = accept | (pend_vld_q & ~apply);
    ready_d    = ~pend_vld_d;
    fd_d       = boundary;
  end

  // Outputs are registered from the next-state values, so a new digit shows
  // on the cycle right after the transition is sampled.
  always_comb begin
    sel_d = 6'h3F;
    seg_d = 8'hFF;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    bright_d = (state_d == SHOW && ctr_d == '0) ? brightness : bright_q;
    sel_on   = (bright_d == 4'hF) ||
               (int'(ctr_d) < (SLOT_CYCLES >> 4) * (int'(bright_d) + 1));
`endif
    if (state_d == SHOW) begin
      sel_d = ~(6'b1 << idx_d);
      if (!shadow_d.blank[idx_d])
        seg_d = decode(shadow_d.digits[{idx_d, 2'b00} +: 4]) & ~{shadow_d.dp[idx_d], 7'b0};
`ifdef SEG_SCAN_BRIGHTNESS_EN
      if (!sel_on) sel_d = 6'h3F;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= '0;
      sel_q      <= 6'h3F;
      seg_q      <= 8'hFF;
      ready_q    <= 1'b1;
      fd_q       <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_q   <= 4'hF;
`endif
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      shadow_q   <= shadow_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      ready_q    <= ready_d;
      fd_q       <= fd_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign upd_ready  = ready_q;
  assign frame_done = fd_q;
  assign seg_ctrl   = {sel_q, seg_q};

endmodule

// File: tb/tb_ax301_segment_scanner.sv
// Bench for ax301_segment_scanner with SLOT_CYCLES=4, BLANK_CYCLES=1.
// Display records (inputs plus hand-decoded segment bytes) drive a per-cycle
// scoreboard of expected {seg_ctrl, frame_done}.
module tb_ax301_segment_scanner;
  localparam int SLOT = 4;
  localparam int BLNK = 1;
  localparam int PER  = SLOT + BLNK;

  logic        CLK = 1'b0, nRST = 1'b0, enable = 1'b0, upd_valid = 1'b0;
  logic        upd_ready, frame_done;
  logic [23:0] upd_digits = '0;
  logic [5:0]  upd_dp = '0, upd_blank = '0;
  logic [3:0]  brightness = 4'hF;
  logic [13:0] seg_ctrl;

  always #5 CLK = ~CLK;

  ax301_segment_scanner #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK)) dut (
    .CLK(CLK), .nRST(nRST), .enable(enable),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digits(upd_digits), .upd_dp(upd_dp), .upd_blank(upd_blank),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .frame_done(frame_done), .seg_ctrl(seg_ctrl)
  );

  typedef struct {
    logic [23:0]     digits;
    logic [5:0]      dp;
    logic [5:0]      blank;
    logic [5:0][7:0] exp_seg;   // index = digit number
  } vec_t;

  typedef struct packed {
    logic [13:0] sc;
    logic        fd;
  } exp_t;

  vec_t vec [7];
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input int r);
    upd_valid  = 1'b1;
    upd_digits = vec[r].digits;
    upd_dp     = vec[r].dp;
    upd_blank  = vec[r].blank;
  endtask

  // After an accept, park garbage on the bus so leaks from it show up.
  task automatic release_bus;
    upd_valid  = 1'b0;
    upd_digits = 24'hFFFFFF;
    upd_dp     = 6'h3F;
    upd_blank  = 6'h15;
  endtask

  task automatic push_frame(input int r, input bit fd0, input int n);
    exp_t e;
    int   d, p;
    for (int c = 0; c < n; c++) begin
      d = c / PER;
      p = c % PER;
      if (p < SLOT) e.sc = {~(6'b1 << d), vec[r].exp_seg[d]};
      else          e.sc = 14'h3FFF;
      e.fd = (c == 0) && fd0;
      sbq.push_back(e);
    end
  endtask

  task automatic push_off(input int n);
    exp_t e;
    e.sc = 14'h3FFF;
    e.fd = 1'b0;
    for (int c = 0; c < n; c++) sbq.push_back(e);
  endtask

  task automatic check_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underrun actual=empty required=entry");
      end else begin
        e = sbq.pop_front();
        chk($sformatf("seg_ctrl@t%0t", $time), seg_ctrl, e.sc);
        chk($sformatf("frame_done@t%0t", $time), frame_done, e.fd);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{24'h543210, 6'h00, 6'h00, {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
    vec[1] = '{24'h888888, 6'h00, 6'h00, {6{8'h80}}};
    vec[2] = '{24'hFEDCB0, 6'b000001, 6'b000100, {8'h8E, 8'h86, 8'hA1, 8'hFF, 8'h83, 8'h40}};
    vec[3] = '{24'hA97654, 6'b100010, 6'h00, {8'h08, 8'h90, 8'hF8, 8'h82, 8'h12, 8'h99}};
    vec[4] = '{24'h123456, 6'h3F, 6'h3F, {6{8'hFF}}};
    vec[5] = vec[0];
    vec[6] = '{24'h000000, 6'h00, 6'h00, {6{8'hC0}}};

    // Reset
    tick(); tick();
    chk("reset_seg_ctrl", seg_ctrl, 14'h3FFF);
    chk("reset_ready", upd_ready, 1);
    chk("reset_frame_done", frame_done, 0);

    // Load in IDLE, then enable
    nRST = 1'b1;
    drive(0);
    tick();
    release_bus();
    chk("idle_accept_ready", upd_ready, 0);
    tick();
    chk("idle_copy_ready", upd_ready, 1);
    enable = 1'b1;
    tick();
    push_frame(0, 1'b0, 30);

    // Mid-frame updates, each applied at the following boundary
    for (int f = 1; f <= 5; f++) begin
      check_cycles(10);
      drive(f);
      check_cycles(1);
      release_bus();
      chk($sformatf("mid_accept_ready_f%0d", f), upd_ready, 0);
      check_cycles(18);
      chk($sformatf("pre_boundary_ready_f%0d", f), upd_ready, 0);
      check_cycles(1);
      chk($sformatf("post_boundary_ready_f%0d", f), upd_ready, 1);
      push_frame(f, 1'b1, (f == 5) ? 17 : 30);
    end

    // Disable during digit 3, hold off past a frame period, re-enable
    check_cycles(16);
    enable = 1'b0;
    check_cycles(1);
    push_off(35);
    check_cycles(35);
    enable = 1'b1;
    push_off(1);
    push_frame(5, 1'b0, 30);
    check_cycles(31);
    push_frame(5, 1'b1, 1);
    check_cycles(1);

    // Reset mid-scan with an update pending: pending and shadow both cleared
    drive(1);
    tick();
    release_bus();
    nRST = 1'b0;
    tick();
    chk("midreset_seg_ctrl", seg_ctrl, 14'h3FFF);
    chk("midreset_ready", upd_ready, 1);
    chk("midreset_frame_done", frame_done, 0);
    nRST = 1'b1;
    tick();
    chk("midreset_pending_cleared", upd_ready, 1);
    push_frame(6, 1'b0, 30);
    check_cycles(30);
    push_frame(6, 1'b1, 1);
    check_cycles(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
